// File: rtl/pattern_game_pkg.sv
// Shared types and constants for the memory-game sequencer.
// The pattern width matches the LFSR generator's thermometer output.
package pattern_game_pkg;

  localparam int PATTERN_W_DEFAULT = 7;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW,
    GAP,
    INPUT,
    WIN,
    FAIL
  } state_t;

  localparam logic [PATTERN_W_DEFAULT-1:0] ALL_ON  = '1;
  localparam logic [PATTERN_W_DEFAULT-1:0] ALL_OFF = '0;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for the SHOW and GAP phases.
// done is high while the count reads zero.
module phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pattern_sequence_ctrl.sv
// Memory-game sequencer: captures one generator pattern per round, plays the
// stored sequence on the LEDs and checks the player's entries against it.
module pattern_sequence_ctrl
  import pattern_game_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int PATTERN_W   = PATTERN_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [PATTERN_W-1:0]       random_value,
  output logic                       stop,
  input  logic [PATTERN_W-1:0]       user_pattern,
  input  logic                       user_enter,
  output logic [PATTERN_W-1:0]       led_pattern,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       win,
  output logic                       fail
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int LEVEL_W    = $clog2(DEPTH + 1);
  localparam int IDX_W      = $clog2(DEPTH);

  localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(DEPTH);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [PATTERN_W-1:0] mem [DEPTH];

  logic                 timer_done;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 last_idx;
  logic [IDX_W-1:0]     wr_idx;
  logic [PATTERN_W-1:0] captured;

  assign last_idx = (LEVEL_W'(idx) == level - LEVEL_W'(1));
  assign wr_idx   = IDX_W'(level - LEVEL_W'(1));
  // A blank pattern would be invisible during playback, so store one lit LED.
  assign captured = (random_value == '0) ? PATTERN_W'(1) : random_value;

  // The timer reloads on the edge that enters SHOW or GAP.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = SHOW_LOAD;
    case (state)
      ADD:  timer_load = 1'b1;
      SHOW: begin
        timer_load  = timer_done;
        timer_value = GAP_LOAD;
      end
      GAP:  timer_load = timer_done && !last_idx;
      default: ;
    endcase
  end

  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // Sequence buffer holds data only; it is deliberately left uncleared on reset.
  always_ff @(posedge clk) begin
    if (state == ADD) begin
      mem[wr_idx] <= captured;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      level       <= '0;
      stop        <= 1'b0;
      led_pattern <= '0;
      busy        <= 1'b0;
      win         <= 1'b0;
      fail        <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, FAIL: begin
          if (start) begin
            state       <= ADD;
            level       <= LEVEL_W'(1);
            stop        <= 1'b1;
            busy        <= 1'b1;
            win         <= 1'b0;
            fail        <= 1'b0;
            led_pattern <= PATTERN_W'(ALL_OFF);
          end
        end
        ADD: begin
          state       <= SHOW;
          stop        <= 1'b0;
          idx         <= '0;
          led_pattern <= (wr_idx == '0) ? captured : mem[0];
        end
        SHOW: begin
          if (timer_done) begin
            state       <= GAP;
            led_pattern <= PATTERN_W'(ALL_OFF);
          end
        end
        GAP: begin
          if (timer_done) begin
            if (last_idx) begin
              state       <= INPUT;
              idx         <= '0;
              led_pattern <= user_pattern;
            end else begin
              state       <= SHOW;
              idx         <= idx + 1'b1;
              led_pattern <= mem[idx + 1'b1];
            end
          end
        end
        INPUT: begin
          led_pattern <= user_pattern;
          if (user_enter) begin
            if (user_pattern != mem[idx]) begin
              state       <= FAIL;
              fail        <= 1'b1;
              busy        <= 1'b0;
              led_pattern <= PATTERN_W'(ALL_OFF);
            end else if (!last_idx) begin
              idx <= idx + 1'b1;
            end else if (level == MAX_LEVEL) begin
              state       <= WIN;
              win         <= 1'b1;
              busy        <= 1'b0;
              led_pattern <= PATTERN_W'(ALL_ON);
            end else begin
              state       <= ADD;
              level       <= level + LEVEL_W'(1);
              stop        <= 1'b1;
              led_pattern <= PATTERN_W'(ALL_OFF);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pattern_sequence_ctrl.md
Name: pattern_sequence_ctrl

Overview:
Memory-game sequencer that consumes the 7-bit thermometer pattern from the LFSR random generator. It freezes the generator through `stop` and captures one new pattern per round into an internal sequence buffer. It then plays the whole sequence on the LEDs and checks the player's switch entries against it. It sits directly downstream of the random generator and drives the board LEDs and status outputs.

Parameters:
DEPTH, 8, maximum sequence length (rounds to win); ≥2
SHOW_CYCLES, 25_000_000, clk cycles each pattern is shown during playback; ≥1
GAP_CYCLES, 12_500_000, clk cycles of blank LEDs after each shown pattern; ≥1
PATTERN_W, 7, pattern width; must equal the generator output width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; starts a new game
random_value  in  PATTERN_W  pattern from the random generator
stop  out  1  freezes the random generator while high
user_pattern  in  PATTERN_W  player switch value, already synchronised
user_enter  in  1  single-cycle pulse; player commits user_pattern
led_pattern  out  PATTERN_W  LED drive
level  out  $clog2(DEPTH+1)  current sequence length, 0 when idle
busy  out  1  high in any state except IDLE, WIN, FAIL
win  out  1  high in WIN
fail  out  1  high in FAIL

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- All outputs are registered.
- Reset values: stop=0, led_pattern=0, level=0, busy=0, win=0, fail=0, state=IDLE, all counters=0. Buffer contents are not cleared.
- Reset mid-operation: returns to IDLE immediately, from any state.
- States: IDLE, ADD, SHOW, GAP, INPUT, WIN, FAIL.
- IDLE/WIN/FAIL on start: level<=1, go to ADD with stop<=1.
  - start is ignored in all other states.
- ADD (exactly 1 cycle):
  - stop=1 during this cycle, so random_value is stable.
  - At the closing edge, mem[level-1]<=random_value; if random_value==0 store 7'b0000001 instead.
  - stop<=0, play index<=0, go to SHOW.
- SHOW:
  - led_pattern=mem[idx] for exactly SHOW_CYCLES cycles, then go to GAP.
- GAP:
  - led_pattern=0 for exactly GAP_CYCLES cycles.
  - Then, if idx==level-1: idx<=0 and go to INPUT; else idx++ and go to SHOW.
- INPUT:
  - led_pattern mirrors user_pattern (registered, 1-cycle latency).
  - On user_enter, compare user_pattern to mem[idx]:
    - Mismatch: go to FAIL.
    - Match, idx<level-1: idx++.
    - Match, idx==level-1, level==DEPTH: go to WIN.
    - Match, idx==level-1, level<DEPTH: level++, stop<=1, go to ADD.
  - No timeout.
- user_enter is ignored outside INPUT. An enter in the same cycle as the INPUT entry transition is ignored.
- WIN: led_pattern=all ones, win=1, level holds DEPTH.
- FAIL: led_pattern=0, fail=1, level holds the failed round.
- Phase timer:
  - Loaded with N-1 on SHOW/GAP entry; the phase ends on the cycle it reads 0.
  - Width is $clog2(max(SHOW_CYCLES,GAP_CYCLES)).
- stop is high only in ADD. The generator therefore advances freely during playback and input, which is the source of randomness.

Decomposition:
- Package pattern_game_pkg holds:
  - state_t enum for the seven states;
  - PATTERN_W_DEFAULT constant;
  - ALL_ON/ALL_OFF pattern constants.
- Sub-module phase_timer:
  - Parameterised down-counter with load value input, load and done outputs.
  - Instantiated once and shared by SHOW and GAP.
- Sequence buffer is an inline register array; no RAM macro.

Test Plan:
All scenarios use DEPTH=3, SHOW_CYCLES=4, GAP_CYCLES=2.
1. Reset, then start with random_value=7'b0000111 -> stop high exactly 1 cycle; mem[0]=0000111; led_pattern=0000111 for 4 cycles, then 0 for 2; then INPUT with level=1, busy=1.
2. Full win: rounds with random_value 0000011, 0011111, 1111111 and correct entries each round -> level steps 1,2,3; round-3 playback shows 3 patterns in order (18 cycles); after the last correct enter, win=1, led_pattern=1111111, busy=0.
3. Wrong entry in round 2 at idx 1 (enter 0000001 vs stored 0011111) -> fail=1 next cycle, led_pattern=0, level=2; a following start -> level=1, state ADD.
4. random_value=0 during ADD -> stored value 0000001, shown in SHOW.
5. user_enter pulses during SHOW/GAP, and start pulses during INPUT -> ignored; state, idx and level unchanged.
6. Assert reset in the middle of a GAP phase -> all outputs 0 asynchronously; after release, start begins a fresh game with level=1.
